// File: rtl/fetch_unit_if.sv
// Instruction-memory fetch bus between fetch_unit (master) and the instruction memory (slave).
// The request and address are held stable until ready or a redirect.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, IF/ID register and a one-entry hold buffer for stalls.
// Optional feature macro FETCH_ALIGN_CHECK_EN adds a sticky misaligned-redirect flag.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                stall,
    input  logic                redirect,
    input  logic [31:0]         redirect_target,
    fetch_unit_if.master        imem,
    output logic                ifid_valid,
    output logic [31:0]         ifid_pc,
    output logic [31:0]         ifid_pc4,
    output logic [31:0]         ifid_instr,
    output logic                fetch_misaligned
);

    typedef enum logic [0:0] {StFetch, StHold} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_pc4_q, ifid_pc4_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [31:0] redirect_pc;
    logic [31:0] pc_plus4;
    logic [31:0] buf_pc_plus4;

    // Low two target bits are always dropped; the flag below only reports them.
    assign redirect_pc  = {redirect_target[31:2], 2'b00};
    assign pc_plus4     = pc_q + 32'd4;
    assign buf_pc_plus4 = buf_pc_q + 32'd4;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ifid_valid_d = ifid_valid_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_instr_d = ifid_instr_q;
        buf_pc_d     = buf_pc_q;
        buf_instr_d  = buf_instr_q;

        if (redirect) begin
            // Redirect wins over stall and ready; any returned or buffered word is dropped.
            pc_d         = redirect_pc;
            ifid_valid_d = 1'b0;
            buf_pc_d     = 32'd0;
            buf_instr_d  = 32'd0;
            state_d      = StFetch;
        end else begin
            unique case (state_q)
                StFetch: begin
                    if (imem.imem_ready) begin
                        if (stall) begin
                            // Park the returned word so the memory handshake can complete.
                            buf_pc_d    = pc_q;
                            buf_instr_d = imem.imem_rdata;
                            state_d     = StHold;
                        end else begin
                            ifid_valid_d = 1'b1;
                            ifid_pc_d    = pc_q;
                            ifid_pc4_d   = pc_plus4;
                            ifid_instr_d = imem.imem_rdata;
                            pc_d         = pc_plus4;
                        end
                    end else if (!stall) begin
                        ifid_valid_d = 1'b0;
                    end
                end
                StHold: begin
                    if (!stall) begin
                        ifid_valid_d = 1'b1;
                        ifid_pc_d    = buf_pc_q;
                        ifid_pc4_d   = buf_pc_plus4;
                        ifid_instr_d = buf_instr_q;
                        pc_d         = buf_pc_plus4;
                        state_d      = StFetch;
                    end
                end
                default: state_d = StFetch;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= StFetch;
            pc_q         <= RESET_PC;
            ifid_valid_q <= 1'b0;
            ifid_pc_q    <= 32'd0;
            ifid_pc4_q   <= 32'd0;
            ifid_instr_q <= 32'd0;
            buf_pc_q     <= 32'd0;
            buf_instr_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_instr_q <= ifid_instr_d;
            buf_pc_q     <= buf_pc_d;
            buf_instr_q  <= buf_instr_d;
        end
    end

    assign imem.imem_req  = (state_q == StFetch);
    assign imem.imem_addr = pc_q;
    assign ifid_valid     = ifid_valid_q;
    assign ifid_pc        = ifid_pc_q;
    assign ifid_pc4       = ifid_pc4_q;
    assign ifid_instr     = ifid_instr_q;

`ifdef FETCH_ALIGN_CHECK_EN
    logic misaligned_q, misaligned_d;

    always_comb begin
        misaligned_d = misaligned_q;
        if (redirect && (redirect_target[1:0] != 2'b00)) begin
            misaligned_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= misaligned_d;
        end
    end

    assign fetch_misaligned = misaligned_q;
`else
    logic unused_target_lsbs;
    assign unused_target_lsbs = ^redirect_target[1:0];
    assign fetch_misaligned   = 1'b0;
`endif

endmodule
